// File: rtl/bcd_counter.sv
// Two-digit packed-BCD up-counter (00..99, wraps) with a single-digit parallel load.
// Reset is asynchronous active-low; Load takes priority over counting.
module bcd_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       Load,
  input  logic [3:0] Din,
  output logic [7:0] Q_out
);

  logic [3:0] r_tens;
  logic [3:0] r_units;

  logic       w_units_max;
  logic       w_tens_max;
  logic [3:0] w_load_units;

  // A load value above 9 saturates so the units nibble is always valid BCD.
  always_comb begin
    w_units_max  = (r_units == 4'd9);
    w_tens_max   = (r_tens == 4'd9);
    w_load_units = (Din > 4'd9) ? 4'd9 : Din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tens  <= 4'd0;
      r_units <= 4'd0;
    end else if (Load) begin
      r_tens  <= 4'd0;
      r_units <= w_load_units;
    end else if (w_units_max) begin
      r_units <= 4'd0;
      r_tens  <= w_tens_max ? 4'd0 : r_tens + 4'd1;
    end else begin
      r_units <= r_units + 4'd1;
    end
  end

  assign Q_out = {r_tens, r_units};

endmodule

// File: tb/tb_bcd_counter.sv
// Self-checking bench for bcd_counter: timed reset/load scenarios, a vector table,
// hand-written carry/wrap sequences and randomized load/reset traffic against a decimal model.
module tb_bcd_counter;

  logic       clk;
  logic       rst_n;
  logic       Load;
  logic [3:0] Din;
  logic [7:0] Q_out;

  int checks   = 0;
  int failures = 0;

  // Reference model: the count as a plain integer 0..99.
  int m_count = 0;

  logic [7:0] exp_q[$];

  typedef struct {
    logic       load;
    logic [3:0] din;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[14];

  bcd_counter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .Load  (Load),
    .Din   (Din),
    .Q_out (Q_out)
  );

  // Clock and reset: 10 ns period, first rising edge at 5 ns.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] to_bcd(input int n);
    logic [3:0] t;
    logic [3:0] u;
    t = 4'(n / 10);
    u = 4'(n % 10);
    return {t, u};
  endfunction

  function automatic int next_count(input int cur, input logic ld, input logic [3:0] d);
    if (ld) return (int'(d) > 9) ? 9 : int'(d);
    return (cur + 1) % 100;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_nibbles(input string name);
    logic ok;
    ok = (Q_out[7:4] <= 4'd9) && (Q_out[3:0] <= 4'd9);
    checks++;
    if (ok !== 1'b1) begin
      failures++;
      $display("FAIL %s: got 0x%h expected both nibbles <= 9 at %0t", name, Q_out, $time);
    end
  endtask

  // Driver: apply inputs, take one rising edge, return 1 ns after it; model follows.
  task automatic drive_edge(input logic ld, input logic [3:0] d);
    Load = ld;
    Din  = d;
    @(posedge clk);
    #1;
    m_count = next_count(m_count, ld, d);
  endtask

  initial begin
    logic       ld;
    logic [3:0] d;
    logic [7:0] exp;

    vecs[0]  = '{1'b0, 4'd0,  8'h06};
    vecs[1]  = '{1'b0, 4'd0,  8'h07};
    vecs[2]  = '{1'b0, 4'd0,  8'h08};
    vecs[3]  = '{1'b0, 4'd0,  8'h09};
    vecs[4]  = '{1'b0, 4'd0,  8'h10};
    vecs[5]  = '{1'b1, 4'hC,  8'h09};
    vecs[6]  = '{1'b0, 4'd0,  8'h10};
    vecs[7]  = '{1'b1, 4'd3,  8'h03};
    vecs[8]  = '{1'b1, 4'd3,  8'h03};
    vecs[9]  = '{1'b1, 4'd3,  8'h03};
    vecs[10] = '{1'b0, 4'd3,  8'h04};
    vecs[11] = '{1'b1, 4'hF,  8'h09};
    vecs[12] = '{1'b0, 4'hF,  8'h10};
    vecs[13] = '{1'b1, 4'd0,  8'h00};

    // Reset and free count.
    rst_n = 1'b0;
    Load  = 1'b0;
    Din   = 4'd0;
    #2;
    check("reset_initial", Q_out, 8'h00);
    @(posedge clk);
    #1;
    check("reset_held_over_edge", Q_out, 8'h00);
    #4;
    rst_n   = 1'b1;
    m_count = 0;
    for (int i = 1; i <= 15; i++) begin
      drive_edge(1'b0, 4'd0);
      check($sformatf("free_count_%0d", i), Q_out, to_bcd(i));
    end

    // Mid-count reset must clear without a clock edge.
    #4;
    rst_n = 1'b0;
    #1;
    check("async_reset_midcount", Q_out, 8'h00);
    m_count = 0;
    #9;
    rst_n = 1'b1;
    drive_edge(1'b0, 4'd0);
    check("after_release_1", Q_out, 8'h01);
    drive_edge(1'b0, 4'd0);
    check("after_release_2", Q_out, 8'h02);
    drive_edge(1'b1, 4'd5);
    check("load_5", Q_out, 8'h05);

    // Vector table: carry, saturation, held load.
    for (int i = 0; i < 14; i++) begin
      drive_edge(vecs[i].load, vecs[i].din);
      check($sformatf("vec_%0d", i), Q_out, vecs[i].exp);
    end

    // Walk from 00 up to 98, then through the 99 -> 00 wrap.
    for (int i = 1; i <= 98; i++) begin
      drive_edge(1'b0, 4'd0);
      check_nibbles($sformatf("nibble_walk_%0d", i));
    end
    check("reach_98", Q_out, 8'h98);
    drive_edge(1'b0, 4'd0);
    check("wrap_99", Q_out, 8'h99);
    drive_edge(1'b0, 4'd0);
    check("wrap_00", Q_out, 8'h00);
    drive_edge(1'b0, 4'd0);
    check("wrap_01", Q_out, 8'h01);

    // Reset wins over Load.
    Load = 1'b1;
    Din  = 4'd7;
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_vs_load_async", Q_out, 8'h00);
    @(posedge clk);
    #1;
    check("reset_vs_load_edge", Q_out, 8'h00);
    Load = 1'b0;
    #3;
    rst_n   = 1'b1;
    m_count = 0;
    drive_edge(1'b1, 4'd7);
    check("load_after_reset", Q_out, 8'h07);
    drive_edge(1'b0, 4'd0);
    check("count_after_load", Q_out, 8'h08);

    // Randomized loads and occasional mid-cycle resets against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        #2;
        rst_n = 1'b0;
        #1;
        check("rand_async_reset", Q_out, 8'h00);
        m_count = 0;
        #2;
        rst_n = 1'b1;
      end
      ld = ($urandom_range(0, 4) == 0);
      d  = 4'($urandom_range(0, 15));
      exp_q.push_back(to_bcd(next_count(m_count, ld, d)));
      drive_edge(ld, d);
      exp = exp_q.pop_front();
      check($sformatf("rand_%0d", i), Q_out, exp);
      check_nibbles($sformatf("rand_nibble_%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
